// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if: request/grant bundle between the AHB masters and the bus arbiter
interface ahb_bus_arbiter_if;
    logic [2:0] hbusreq;
    logic [2:0] hlock;
    logic       hready;
    logic [1:0] hresp;
    logic [2:0] hgrant;
    logic [1:0] hmaster;
    logic [1:0] hmaster_d;
    logic       hmastlock;
    modport master (
        output hbusreq, hlock, hready, hresp,
        input  hgrant, hmaster, hmaster_d, hmastlock
    );
    modport slave (
        input  hbusreq, hlock, hready, hresp,
        output hgrant, hmaster, hmaster_d, hmastlock
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: three-master AHB arbiter with hold limit and locked tenures; define ARB_ROUND_ROBIN_EN for rotating priority
module ahb_bus_arbiter #(
    parameter int DEF_MASTER = 0,
    parameter int MAX_HOLD   = 16,
    parameter int CNT_W      = 5
) (
    input logic              hclk,
    input logic              hresetn,
    ahb_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN, ARB_LOCK} state_t;
    localparam logic [1:0]       DEF     = 2'(DEF_MASTER);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       owner;
    logic [1:0]       start;
    logic [1:0]       win;
    logic [2:0]       elig;
    logic             retry;
    logic             timeout;
    logic             lock_hold;
    logic             keep;
`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr;
    assign start = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
`else
    assign start = 2'd0;
`endif
    assign owner     = bus.hmaster;
    assign retry     = bus.hresp inside {2'b10, 2'b11};
    // the current owner is never eligible when the bus is re-arbitrated
    assign elig      = bus.hbusreq & ~bus.hgrant;
    assign timeout   = (cnt == CNT_MAX) && |elig;
    assign lock_hold = (state == ARB_LOCK) && bus.hlock[owner];
    assign keep      = (state != ARB_IDLE) && (lock_hold || (!retry && bus.hbusreq[owner] && !timeout));
    // first eligible requester found searching upward from start, wrapping at 3
    always_comb begin
        win = 2'd0;
        for (int k = 2; k >= 0; k--)
            if (elig[(int'(start) + k) % 3]) win = 2'((int'(start) + k) % 3);
    end
    // arbitration state and registered bus outputs, advanced only on hready edges
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state         <= ARB_IDLE;
            cnt           <= '0;
            bus.hgrant    <= '0;
            bus.hmaster   <= DEF;
            bus.hmaster_d <= DEF;
            bus.hmastlock <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr           <= 2'd2;
`endif
        end else if (bus.hready) begin
            bus.hmaster_d <= bus.hmaster;
            if (keep) begin
                state         <= bus.hlock[owner] ? ARB_LOCK : ARB_OWN;
                cnt           <= bus.hlock[owner] ? '0 : (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                bus.hmastlock <= bus.hlock[owner];
            end else if (|elig) begin
                state         <= bus.hlock[win] ? ARB_LOCK : ARB_OWN;
                cnt           <= '0;
                bus.hgrant    <= 3'b001 << win;
                bus.hmaster   <= win;
                bus.hmastlock <= bus.hlock[win];
`ifdef ARB_ROUND_ROBIN_EN
                ptr           <= win;
`endif
            end else begin
                state         <= ARB_IDLE;
                cnt           <= '0;
                bus.hgrant    <= '0;
                bus.hmaster   <= DEF;
                bus.hmastlock <= 1'b0;
            end
        end
    end
    // the grant must never be shared between masters
    assert property (@(posedge hclk) disable iff (!hresetn) $onehot0(bus.hgrant));
endmodule
